mix_add_char_unit: RTL and testbench
====================================

MIX_ADD_CHAR_UNIT -- requirements
Module: mix_add_char_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset.
REQ-002 The module SHALL have no parameters; all widths are fixed.
REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; asserted when 0.
- add_start  in  1  one-cycle ADD request.
- char_start  in  1  one-cycle CHAR request.
- in1  in  31  accumulator word (rA); bit 30 is the sign (1 = negative), bits 29:0 are the magnitude.
- in2  in  31  operand word, same format as in1.
- add_stop  out  1  ADD result-valid pulse.
- add_out  out  31  ADD result word.
- overflow  out  1  ADD overflow; valid while add_stop = 1.
- char_stop  out  1  CHAR done pulse.
- char_out  out  60  ten 6-bit character codes; bits 59:54 hold the most significant digit.

Function
REQ-004 add_stop SHALL be add_start delayed by one register stage: high exactly one cycle, one cycle after add_start.
REQ-005 add_out and overflow SHALL be combinational functions of in1 and in2 in the add_stop cycle. in2 is only valid from that cycle. Their value while add_stop = 0 is don't-care.
REQ-006 Equal signs: magnitude = (|in1| + |in2|) mod 2^30; sign = sign of in1; overflow = carry out of bit 29.
REQ-007 Different signs: magnitude = larger magnitude minus smaller; sign = sign of the operand with the larger magnitude; overflow = 0.
REQ-008 Different signs with equal magnitudes: result SHALL be magnitude 0 with the sign of in1.
REQ-009 CHAR SHALL sample in1[29:0] in the char_start cycle and ignore in1 afterwards.
REQ-010 CHAR SHALL convert the magnitude to 10 unsigned decimal digits, zero-padded.
REQ-011 Digit d SHALL be encoded as the 6-bit code 30 + d, so d = 0 gives 30 and d = 9 gives 39.
REQ-012 char_stop SHALL pulse high for exactly one cycle, 31 cycles after the char_start cycle.
REQ-013 char_out SHALL update in the char_stop cycle and SHALL hold that value until the next conversion completes.
REQ-014 While a conversion is in progress, char_start SHALL be ignored.
REQ-015 char_start in the char_stop cycle SHALL be accepted as a new conversion.
REQ-016 ADD and CHAR SHALL operate independently. Simultaneous add_start and char_start SHALL both be honoured.
REQ-017 The CHAR state machine SHALL have two states:
- IDLE to CONV on char_start.
- CONV to IDLE after 30 iterations, asserting char_stop.
REQ-018 CHAR SHALL use iterative shift-and-add-3 (double-dabble), one bit per cycle.

Reset
REQ-019 While reset = 0 at a rising edge, the module SHALL clear add_stop, char_stop, char_out (to 0), the CHAR state (to IDLE) and the iteration counter.
REQ-020 Reset during a conversion SHALL abort it with no char_stop pulse.
REQ-021 Reset SHALL have priority over add_start and char_start in the same cycle.
REQ-022 overflow and add_out SHALL carry no reset requirement (combinational).

Structure
REQ-023 A shared package SHALL hold these constants: WORD_W = 31, MAG_W = 30, SIGN_BIT = 30, N_DIGITS = 10, CHAR_ZERO = 30, CHAR_ITERS = 30.
REQ-024 The package SHALL hold the CHAR state enumeration {IDLE, CONV}.
REQ-025 CHAR SHALL be implemented in one sub-module, mix_bin2char_conv (clk, reset, start, in[29:0], stop, out[59:0]).
REQ-026 ADD logic SHALL remain inline in mix_add_char_unit.

Verification
REQ-027 ADD +5 + +7 -> add_stop one cycle after add_start; add_out = +12; overflow = 0.
REQ-028 ADD +1073741823 + +1 -> add_out magnitude 0, sign 0; overflow = 1.
REQ-029 ADD +5 + -8 -> -3 with overflow 0; ADD -5 + +5 -> magnitude 0, sign 1; ADD +9 + -4 -> +5.
REQ-030 CHAR with in1 magnitude 12977699 -> after 31 cycles, char_stop pulses once and char_out codes, MSD first, are 30,30,31,32,39,37,37,36,39,39.
REQ-031 CHAR with magnitude 1073741823 -> codes 31,30,37,33,37,34,31,38,32,33. A second char_start at cycle 5 is ignored, so only one char_stop occurs.
REQ-032 Reset low at cycle 10 of a CHAR conversion -> no char_stop, char_out = 0. A CHAR of 0 afterwards -> ten codes of 30.

Source files
------------

// File: rtl/mix_add_char_unit_pkg.sv
// mix_add_char_unit_pkg: shared widths, character constants and CHAR state encoding.
package mix_add_char_unit_pkg;
  localparam int WORD_W = 31;
  localparam int MAG_W = 30;
  localparam int SIGN_BIT = 30;
  localparam int N_DIGITS = 10;
  localparam logic [5:0] CHAR_ZERO = 6'd30;
  localparam int CHAR_ITERS = 30;
  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } char_state_t;
endpackage

// File: rtl/mix_bin2char_conv.sv
// mix_bin2char_conv: iterative double-dabble of a 30-bit magnitude into ten 6-bit digit codes.
module mix_bin2char_conv
  import mix_add_char_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MAG_W-1:0]      in,
  output logic                  stop,
  output logic [6*N_DIGITS-1:0] out
);
  char_state_t r_state, w_state_nxt;
  logic [4:0] r_cnt;
  logic [MAG_W-1:0] r_bin;
  logic [4*N_DIGITS-1:0] r_bcd, w_adj, w_bcd_nxt;
  logic [6*N_DIGITS-1:0] r_out, w_codes;
  logic r_stop, w_load, w_last;
  for (genvar d = 0; d < N_DIGITS; d++) begin : g_dig
    assign w_adj[4*d+:4] = (r_bcd[4*d+:4] >= 4'd5) ? r_bcd[4*d+:4] + 4'd3 : r_bcd[4*d+:4];
    assign w_codes[6*d+:6] = CHAR_ZERO + {2'b00, w_bcd_nxt[4*d+:4]};
  end
  // the top digit never exceeds 1 for a 30-bit input, so the dropped carry bit is always 0
  assign w_bcd_nxt = (4*N_DIGITS)'({w_adj, r_bin[MAG_W-1]});
  assign w_load = (r_state == IDLE) && start;
  assign w_last = (r_state == CONV) && (r_cnt == 5'(CHAR_ITERS - 1));
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_load ? CONV : (w_last ? IDLE : r_state);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_stop  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stop  <= w_last;
      if (w_load) begin
        r_bin <= in;
        r_bcd <= '0;
        r_cnt <= '0;
      end else if (r_state == CONV) begin
        r_bin <= r_bin << 1;
        r_bcd <= w_bcd_nxt;
        r_cnt <= r_cnt + 5'd1;
      end
      if (w_last) r_out <= w_codes;
    end
  end
  assign stop = r_stop;
  assign out = r_out;
endmodule

// File: rtl/mix_add_char_unit.sv
// mix_add_char_unit: sign-magnitude ADD with one-cycle valid and a decimal CHAR converter.
module mix_add_char_unit
  import mix_add_char_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  add_start,
  input  logic                  char_start,
  input  logic [WORD_W-1:0]     in1,
  input  logic [WORD_W-1:0]     in2,
  output logic                  add_stop,
  output logic [WORD_W-1:0]     add_out,
  output logic                  overflow,
  output logic                  char_stop,
  output logic [6*N_DIGITS-1:0] char_out
);
  logic r_add_stop;
  logic w_sa, w_sb, w_same, w_b_gt;
  logic [MAG_W-1:0] w_a, w_b, w_diff;
  logic [MAG_W:0] w_sum;
  assign w_sa = in1[SIGN_BIT];
  assign w_sb = in2[SIGN_BIT];
  assign w_a = in1[MAG_W-1:0];
  assign w_b = in2[MAG_W-1:0];
  assign w_same = (w_sa == w_sb);
  assign w_sum = {1'b0, w_a} + {1'b0, w_b};
  assign w_b_gt = (w_b > w_a);
  assign w_diff = w_b_gt ? w_b - w_a : w_a - w_b;
  // equal magnitudes with opposite signs fall to the in1 sign via w_b_gt = 0
  assign add_out = w_same ? {w_sa, w_sum[MAG_W-1:0]} : {w_b_gt ? w_sb : w_sa, w_diff};
  assign overflow = w_same & w_sum[MAG_W];
  always_ff @(posedge clk) begin
    if (!reset) r_add_stop <= 1'b0;
    else r_add_stop <= add_start;
  end
  assign add_stop = r_add_stop;
  mix_bin2char_conv u_conv (
    .clk   (clk),
    .reset (reset),
    .start (char_start),
    .in    (in1[MAG_W-1:0]),
    .stop  (char_stop),
    .out   (char_out)
  );
endmodule

// File: tb/tb_mix_add_char_unit.sv
// tb_mix_add_char_unit: randomized self-checking bench against an arithmetic reference model.
module tb_mix_add_char_unit;
  logic clk = 1'b0;
  logic reset, add_start, char_start, add_stop, overflow, char_stop;
  logic [30:0] in1, in2, add_out;
  logic [59:0] char_out;
  int vectors = 0;
  int errs = 0;
  mix_add_char_unit dut (
    .clk(clk), .reset(reset), .add_start(add_start), .char_start(char_start),
    .in1(in1), .in2(in2), .add_stop(add_stop), .add_out(add_out), .overflow(overflow),
    .char_stop(char_stop), .char_out(char_out)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] add_model(input logic [30:0] a, input logic [30:0] b);
    longint ma = longint'(a[29:0]);
    longint mb = longint'(b[29:0]);
    longint va = a[30] ? -ma : ma;
    longint vb = b[30] ? -mb : mb;
    longint s;
    logic [29:0] mag;
    logic sg, ov;
    if (a[30] == b[30]) begin
      s = ma + mb;
      mag = 30'(s % 64'd1073741824);
      ov = (s >= 64'd1073741824);
      sg = a[30];
    end else begin
      s = va + vb;
      mag = 30'(s < 0 ? -s : s);
      ov = 1'b0;
      sg = (s < 0) ? 1'b1 : ((s > 0) ? 1'b0 : a[30]);
    end
    return {ov, sg, mag};
  endfunction
  function automatic logic [59:0] char_model(input logic [29:0] m);
    logic [59:0] r = '0;
    int unsigned v = int'(m);
    for (int i = 0; i < 10; i++) begin
      r[6*i+:6] = 6'(30 + v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  task automatic start_char(input logic [29:0] m);
    in1 = {1'($urandom), m};
    char_start = 1'b1;
    tick;
    char_start = 1'b0;
    in1 = 31'($urandom);
  endtask
  task automatic test_reset;
    reset = 1'b0; add_start = 1'b1; char_start = 1'b1;
    in1 = 31'($urandom); in2 = 31'($urandom);
    tick; tick;
    add_start = 1'b0; char_start = 1'b0;
    vectors++;
    if (add_stop !== 1'b0 || char_stop !== 1'b0 || char_out !== 60'd0) begin
      errs++;
      $display("FAIL reset add_stop=%b char_stop=%b char_out=%h exp 0 0 0", add_stop, char_stop, char_out);
    end
    reset = 1'b1;
    tick;
    vectors++;
    if (add_stop !== 1'b0 || char_stop !== 1'b0) begin
      errs++;
      $display("FAIL reset_priority add_stop=%b char_stop=%b exp 0 0", add_stop, char_stop);
    end
  endtask
  task automatic test_add;
    logic [30:0] ta [5] = '{31'h00000005, 31'h3FFFFFFF, 31'h00000005, 31'h40000005, 31'h00000009};
    logic [30:0] tb [5] = '{31'h00000007, 31'h00000001, 31'h40000008, 31'h00000005, 31'h40000004};
    logic [31:0] fx [5] = '{32'h0000000C, 32'h80000000, 32'h40000003, 32'h40000000, 32'h00000005};
    logic [30:0] a, b;
    logic [31:0] e;
    for (int i = 0; i < 45; i++) begin
      a = (i < 5) ? ta[i] : 31'($urandom);
      b = (i < 5) ? tb[i] : 31'($urandom);
      if (i >= 5 && i % 4 == 0) b = {~a[30], a[29:0]};
      if (i >= 5 && i % 7 == 0) b = {a[30], ~a[29:0]};
      e = (i < 5) ? fx[i] : add_model(a, b);
      in1 = a; in2 = 31'($urandom); add_start = 1'b1;
      tick;
      add_start = 1'b0; in2 = b;
      #1;
      vectors++;
      if (add_stop !== 1'b1 || {overflow, add_out} !== e) begin
        errs++;
        $display("FAIL add a=%h b=%h stop=%b ovf=%b out=%h exp stop=1 ovf/out=%h", a, b, add_stop, overflow, add_out, e);
      end
      tick;
      vectors++;
      if (add_stop !== 1'b0) begin
        errs++;
        $display("FAIL add_pulse a=%h stop=%b exp 0", a, add_stop);
      end
    end
  endtask
  task automatic test_char;
    logic [29:0] m;
    logic [59:0] e;
    int n;
    for (int i = 0; i < 6; i++) begin
      m = (i == 0) ? 30'd12977699 : (i == 1) ? 30'h3FFFFFFF : 30'($urandom);
      e = (i == 0) ? 60'({6'd30, 6'd30, 6'd31, 6'd32, 6'd39, 6'd37, 6'd37, 6'd36, 6'd39, 6'd39})
                   : char_model(m);
      start_char(m);
      n = 1;
      while (!char_stop && n < 40) begin
        tick;
        n++;
      end
      vectors++;
      if (n !== 31 || char_out !== e) begin
        errs++;
        $display("FAIL char m=%0d latency=%0d out=%h exp latency=31 out=%h", m, n, char_out, e);
      end
      tick;
      vectors++;
      if (char_stop !== 1'b0 || char_out !== e) begin
        errs++;
        $display("FAIL char_hold m=%0d stop=%b out=%h exp stop=0 out=%h", m, char_stop, char_out, e);
      end
    end
  endtask
  task automatic test_char_ignore;
    int n = 1;
    int stops = 0;
    int first = 0;
    start_char(30'h3FFFFFFF);
    while (n < 70) begin
      if (n == 5) begin
        char_start = 1'b1;
        in1 = 31'h00012345;
      end
      tick;
      n++;
      char_start = 1'b0;
      if (char_stop) begin
        stops++;
        if (first == 0) first = n;
      end
    end
    vectors++;
    if (stops !== 1 || first !== 31 || char_out !== char_model(30'h3FFFFFFF)) begin
      errs++;
      $display("FAIL char_ignore stops=%0d at=%0d out=%h exp 1 at 31 out=%h", stops, first, char_out, char_model(30'h3FFFFFFF));
    end
  endtask
  task automatic test_char_reset;
    int stops = 0;
    int n = 1;
    start_char(30'($urandom));
    while (n < 10) begin
      tick;
      n++;
    end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (char_stop) stops++;
    end
    vectors++;
    if (stops !== 0 || char_out !== 60'd0) begin
      errs++;
      $display("FAIL char_abort stops=%0d out=%h exp 0 0", stops, char_out);
    end
    start_char(30'd0);
    n = 1;
    while (!char_stop && n < 40) begin
      tick;
      n++;
    end
    vectors++;
    if (n !== 31 || char_out !== {10{6'd30}}) begin
      errs++;
      $display("FAIL char_zero latency=%0d out=%h exp 31 %h", n, char_out, {10{6'd30}});
    end
  endtask
  task automatic test_back_to_back;
    logic [29:0] m1 = 30'($urandom);
    logic [29:0] m2 = 30'($urandom);
    int n = 1;
    start_char(m1);
    while (!char_stop && n < 40) begin
      tick;
      n++;
    end
    vectors++;
    if (n !== 31 || char_out !== char_model(m1)) begin
      errs++;
      $display("FAIL b2b_first latency=%0d out=%h exp 31 %h", n, char_out, char_model(m1));
    end
    start_char(m2);
    n = 1;
    while (!char_stop && n < 40) begin
      tick;
      n++;
    end
    vectors++;
    if (n !== 31 || char_out !== char_model(m2)) begin
      errs++;
      $display("FAIL b2b_second latency=%0d out=%h exp 31 %h", n, char_out, char_model(m2));
    end
  endtask
  task automatic test_simultaneous;
    logic [29:0] m = 30'($urandom);
    logic [30:0] b = 31'($urandom);
    logic [31:0] e = add_model({1'b1, m}, b);
    int n = 1;
    in1 = {1'b1, m}; in2 = 31'($urandom);
    add_start = 1'b1; char_start = 1'b1;
    tick;
    add_start = 1'b0; char_start = 1'b0; in2 = b;
    #1;
    vectors++;
    if (add_stop !== 1'b1 || {overflow, add_out} !== e) begin
      errs++;
      $display("FAIL simul_add stop=%b ovf/out=%h exp 1 %h", add_stop, {overflow, add_out}, e);
    end
    in1 = 31'($urandom);
    while (!char_stop && n < 40) begin
      tick;
      n++;
    end
    vectors++;
    if (n !== 31 || char_out !== char_model(m)) begin
      errs++;
      $display("FAIL simul_char latency=%0d out=%h exp 31 %h", n, char_out, char_model(m));
    end
  endtask
  initial begin
    reset = 1'b0; add_start = 1'b0; char_start = 1'b0; in1 = '0; in2 = '0;
    test_reset;
    test_add;
    test_char;
    test_char_ignore;
    test_char_reset;
    test_back_to_back;
    test_simultaneous;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
